// File: rtl/transpose_stream_unit.sv
// -----------------------------------------------------------------------------
// transpose_stream_unit
//
// Streaming N x N tile transposer with two ping-pong tile banks. Rows enter one
// per beat; each finished tile is returned one column per beat (transpose mode)
// or one row per beat (pass mode). The mode is captured on the first row of
// every tile. One bank fills while the other drains, so a steady stream moves
// one beat per cycle in each direction.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_data       one tile row, element c at [c*DATA_WIDTH +: DATA_WIDTH]
//   in_valid      in_data valid
//   in_ready      a row can be accepted (depends on registered state only)
//   in_transpose  tile mode, sampled on the tile's first accepted row
//   out_data      one output beat, same element packing (0 when idle)
//   out_valid     out_data valid
//   out_ready     downstream accepts the beat
//   out_last      final beat of a tile, qualified by out_valid
//   busy          a bank is full or a tile is partially written
// -----------------------------------------------------------------------------
module transpose_stream_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int TILE_DIM   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [TILE_DIM*DATA_WIDTH-1:0] in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_transpose,
    output logic [TILE_DIM*DATA_WIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           busy
);

    localparam int CNT_W = $clog2(TILE_DIM);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TILE_DIM - 1);

    typedef logic [DATA_WIDTH-1:0] elem_t;

    // Tile storage: bank, row, column.
    elem_t bank_q [2][TILE_DIM][TILE_DIM];

    logic [1:0]       full_q,    full_d;
    logic [1:0]       mode_q,    mode_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] wr_row_q,  wr_row_d;
    logic [CNT_W-1:0] rd_col_q,  rd_col_d;

    logic accept;
    logic rd_fire;

    // Both handshakes depend only on registered flags, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign out_last  = out_valid && (rd_col_q == CNT_MAX);
    assign busy      = (|full_q) || (wr_row_q != '0);

    assign accept  = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;

    // Next-state for the control registers. A write completion always targets
    // a non-full bank and a read completion a full one, so when both finish in
    // the same cycle they touch different flags and both updates apply.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        full_d    = full_q;
        mode_d    = mode_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_col_d  = rd_col_q;

        if (accept) begin
            if (wr_row_q == '0) begin
                mode_d[wr_bank_q] = in_transpose;
            end
            if (wr_row_q == CNT_MAX) begin
                wr_row_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_row_d = wr_row_q + CNT_W'(1);
            end
        end

        if (rd_fire) begin
            if (rd_col_q == CNT_MAX) begin
                rd_col_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end else begin
                rd_col_d = rd_col_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= '0;
            mode_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_col_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            full_q    <= full_d;
            mode_q    <= mode_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_col_q  <= rd_col_d;
        end
    end

    // Row write into the filling bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage array is reset on purpose so a reset leaves no
            // residue of discarded tiles; this costs reset fan-out on every bit.
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < TILE_DIM; r++) begin
                    for (int c = 0; c < TILE_DIM; c++) begin
                        bank_q[b][r][c] <= '0;
                    end
                end
            end
        end else if (accept) begin
            for (int c = 0; c < TILE_DIM; c++) begin
                bank_q[wr_bank_q][wr_row_q][c] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output beat: column rd_col in transpose mode, row rd_col in pass mode.
    // Driven straight from registered storage, hence stable during a stall.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int e = 0; e < TILE_DIM; e++) begin
                if (mode_q[rd_bank_q]) begin
                    out_data[e*DATA_WIDTH +: DATA_WIDTH] = bank_q[rd_bank_q][e][rd_col_q];
                end else begin
                    out_data[e*DATA_WIDTH +: DATA_WIDTH] = bank_q[rd_bank_q][rd_col_q][e];
                end
            end
        end
    end

endmodule
